ucode_loader: RTL

- Upstream feeder for the uCode CPU.
- Receives a framed byte stream (e.g. from a UART receiver) and assembles it into 16-bit uCode words.
- Drives the CPU's uCode memory write port (write-enable, address, data) and its run input.
- Asserts run only after a complete frame with a valid checksum, so a corrupted download never executes.

---
 rtl/ucode_loader_pkg.sv | 27 ++
 rtl/ucode_loader_if.sv | 33 +++
 rtl/ucode_loader_timer.sv | 30 +++
 rtl/ucode_loader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ucode_loader_pkg.sv
// Shared definitions for the uCode loader: FSM encoding, frame sync byte and
// the byte placement of each received word.
package ucode_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_RUN,
    S_FAIL
  } state_e;

  localparam int unsigned BYTE_W    = 8;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // Words arrive high byte first; these give each byte's position in the word.
  localparam int unsigned HI_LSB = 8;
  localparam int unsigned LO_LSB = 0;

  function automatic logic is_busy(input state_e s);
    return s inside {S_ADDR, S_COUNT, S_HI, S_LO, S_CSUM};
  endfunction

endpackage

// File: rtl/ucode_loader_if.sv
// Byte-stream input and uCode memory/run outputs of the loader, bundled so
// the byte source, the CPU side and the loader share one definition.
interface ucode_loader_if #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) ();
  import ucode_loader_pkg::*;

  // i_rx_wr is a one-cycle strobe qualifying i_rx_data; there is no ready,
  // every strobe is consumed. o_wr is a one-cycle strobe qualifying
  // o_waddr/o_wdata; the memory must accept it unconditionally.
  logic [BYTE_W-1:0]  i_rx_data;
  logic               i_rx_wr;
  logic               o_wr;
  logic [ADDR_SZ-1:0] o_waddr;
  logic [DATA_SZ-1:0] o_wdata;
  logic               o_run;
  logic               o_busy;
  logic               o_error;

  // master: byte source plus the CPU that observes the loader outputs
  modport master (
    output i_rx_data, i_rx_wr,
    input  o_wr, o_waddr, o_wdata, o_run, o_busy, o_error
  );

  // slave: the loader itself
  modport slave (
    input  i_rx_data, i_rx_wr,
    output o_wr, o_waddr, o_wdata, o_run, o_busy, o_error
  );

endinterface

// File: rtl/ucode_loader_timer.sv
// Inter-byte watchdog: reloads on every received byte and flags expiry after
// TIMEOUT enabled cycles without one.
module loader_timer #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reload,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Reloading to TIMEOUT-1 makes expiry land on the TIMEOUT-th idle edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_reload) begin
      cnt <= CNT_W'(TIMEOUT - 1);
    end else if (i_enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_expired = i_enable && !i_reload && (cnt == '0);

endmodule

// File: rtl/ucode_loader.sv
// Frame parser that turns a SYNC/ADDR/COUNT/words/CSUM byte stream into uCode
// memory writes and raises run only after a frame with a good checksum.
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int          DATA_SZ = 16,
  parameter int          ADDR_SZ = 8,
  parameter logic [7:0]  SYNC    = SYNC_BYTE,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ucode_loader_if.slave bus,
  output state_e        o_state
);

  state_e             state;
  logic [ADDR_SZ-1:0] base;
  logic [7:0]         count;
  logic [7:0]         idx;
  logic [7:0]         hi_byte;
  logic [7:0]         csum;
  logic               wr_q;
  logic [ADDR_SZ-1:0] waddr_q;
  logic [DATA_SZ-1:0] wdata_q;
  logic               run_q;
  logic               err_q;
  logic               tmr_expired;

  logic [7:0]         rx;
  logic [7:0]         sum_next;
  logic [7:0]         idx_next;
  logic [DATA_SZ-1:0] word_next;

  assign rx        = bus.i_rx_data;
  assign sum_next  = csum + rx;
  assign idx_next  = idx + 8'd1;
  assign word_next = (DATA_SZ'(hi_byte) << HI_LSB) | (DATA_SZ'(rx) << LO_LSB);

  loader_timer #(
    .TIMEOUT (int'(TIMEOUT))
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_reload  (bus.i_rx_wr),
    .i_enable  (is_busy(state)),
    .o_expired (tmr_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      base    <= '0;
      count   <= '0;
      idx     <= '0;
      hi_byte <= '0;
      csum    <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      // A byte always takes priority over a timeout expiring in the same cycle.
      if (bus.i_rx_wr) begin
        case (state)
          S_IDLE: begin
            if (rx == SYNC) state <= S_ADDR;
          end
          S_ADDR: begin
            base  <= ADDR_SZ'(rx);
            csum  <= rx;
            state <= S_COUNT;
          end
          S_COUNT: begin
            count <= rx;
            csum  <= sum_next;
            idx   <= '0;
            state <= (rx == 8'd0) ? S_CSUM : S_HI;
          end
          S_HI: begin
            hi_byte <= rx;
            csum    <= sum_next;
            state   <= S_LO;
          end
          S_LO: begin
            csum    <= sum_next;
            wr_q    <= 1'b1;
            waddr_q <= base + ADDR_SZ'(idx);
            wdata_q <= word_next;
            idx     <= idx_next;
            state   <= (idx_next == count) ? S_CSUM : S_HI;
          end
          S_CSUM: begin
            csum <= sum_next;
            if (sum_next == 8'd0) begin
              state <= S_RUN;
              run_q <= 1'b1;
              err_q <= 1'b0;
            end else begin
              state <= S_FAIL;
              run_q <= 1'b0;
              err_q <= 1'b1;
            end
          end
          S_RUN: begin
            // Dropping run here guarantees no write lands while the CPU runs.
            if (rx == SYNC) begin
              run_q <= 1'b0;
              state <= S_ADDR;
            end
          end
          S_FAIL: begin
            if (rx == SYNC) begin
              err_q <= 1'b0;
              state <= S_ADDR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (tmr_expired) begin
        state <= S_FAIL;
        run_q <= 1'b0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_wr    = wr_q;
  assign bus.o_waddr = waddr_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_run   = run_q;
  assign bus.o_error = err_q;
  assign bus.o_busy  = is_busy(state);
  assign o_state     = state;

endmodule
